// File: rtl/uart_pkg.sv
// Shared UART-side definitions: frame parser state encoding and serial-link constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OP,
        ADDR,
        DATA,
        CSUM
    } frame_state_e;

    localparam logic [7:0]  DEFAULT_SOF_BYTE       = 8'h7E;
    localparam int unsigned UART_CLOCK_BIT         = 434;
    localparam int unsigned FRAME_LEN              = 5;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 8680;
    localparam int unsigned TIMEOUT_CNT_W          = 14;

endpackage

// File: rtl/edge_strobe.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition of level_i.
module edge_strobe (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    // NOTE: state uses <= so every flop samples pre-edge values; level_q resets high so a
    // level already asserted when reset releases is not mistaken for a fresh edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SOF/op/addr/data/XOR-checksum frames from uart_rx bytes into a valid/ready command.
// Inter-byte timeout is compiled in only when UART_FRAME_PARSER_TIMEOUT_EN is defined.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = DEFAULT_SOF_BYTE
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_op,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       err_csum,
    output logic       err_overrun,
    output logic       err_timeout
);

    frame_state_e state_q, state_d;
    logic [7:0]   op_s_q, op_s_d;
    logic [7:0]   addr_s_q, addr_s_d;
    logic [7:0]   data_s_q, data_s_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic [7:0]   cmd_op_q, cmd_op_d;
    logic [7:0]   cmd_addr_q, cmd_addr_d;
    logic [7:0]   cmd_data_q, cmd_data_d;
    logic         err_csum_q, err_csum_d;
    logic         err_overrun_q, err_overrun_d;
    logic         err_timeout_q, err_timeout_d;
    logic         byte_stb;
    logic         csum_ok;
    logic         timeout_hit;

    edge_strobe u_rx_done_edge (
        .clock   (clock),
        .reset   (reset),
        .level_i (rx_done),
        .pulse_o (byte_stb)
    );

    assign csum_ok = (rx_data == (op_s_q ^ addr_s_q ^ data_s_q));

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_CNT_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (byte_stb || (state_q == IDLE)) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + TIMEOUT_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TIMEOUT_LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        op_s_d        = op_s_q;
        addr_s_d      = addr_s_q;
        data_s_d      = data_s_q;
        cmd_valid_d   = cmd_valid_q & ~cmd_ready;
        cmd_op_d      = cmd_op_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_data_d    = cmd_data_q;
        err_csum_d    = 1'b0;
        err_overrun_d = 1'b0;
        err_timeout_d = 1'b0;

        if (timeout_hit) begin
            // A strobe landing on the timeout cycle is discarded with the partial frame.
            state_d       = IDLE;
            err_timeout_d = 1'b1;
        end else if (byte_stb) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SOF_BYTE) begin
                        state_d = OP;
                    end
                end
                OP: begin
                    op_s_d  = rx_data;
                    state_d = ADDR;
                end
                ADDR: begin
                    addr_s_d = rx_data;
                    state_d  = DATA;
                end
                DATA: begin
                    data_s_d = rx_data;
                    state_d  = CSUM;
                end
                CSUM: begin
                    state_d = IDLE;
                    if (!csum_ok) begin
                        err_csum_d = 1'b1;
                    end else if (cmd_valid_q && !cmd_ready) begin
                        err_overrun_d = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_op_d    = op_s_q;
                        cmd_addr_d  = addr_s_q;
                        cmd_data_d  = data_s_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            op_s_q        <= '0;
            addr_s_q      <= '0;
            data_s_q      <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_op_q      <= '0;
            cmd_addr_q    <= '0;
            cmd_data_q    <= '0;
            err_csum_q    <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_s_q        <= op_s_d;
            addr_s_q      <= addr_s_d;
            data_s_q      <= data_s_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_op_q      <= cmd_op_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_data_q    <= cmd_data_d;
            err_csum_q    <= err_csum_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_data    = cmd_data_q;
    assign err_csum    = err_csum_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: frame-level reference model feeds an expected-event
// queue; a monitor pops and compares whenever the DUT presents a command or an error pulse.
module tb_uart_frame_parser;

    localparam logic [7:0] SOF    = 8'h7E;
    localparam int         HOLD_L = 434;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int         TIMEOUT = 8680;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       err_csum;
    logic       err_overrun;
    logic       err_timeout;

    uart_frame_parser dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .err_csum    (err_csum),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int {EV_CMD, EV_CSUM, EV_OVR, EV_TO} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] op;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input ev_kind_e k, input logic [7:0] o, input logic [7:0] a,
                                    input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.op   = o;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    // Reference model: byte stream -> frames collected in a queue, decided on the fifth byte.
    logic [7:0] frame_q[$];
    bit         m_prev;
    bit         m_held;
    bit         m_stb;
    bit         m_load;
    bit         m_to;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    int         m_gap;
    int         cyc;
    int         last_stb_cyc;
`endif

    always @(posedge clock) begin
        if (reset) begin
            frame_q.delete();
            m_prev = 1'b1;
            m_held = 1'b0;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
            m_gap  = 0;
`endif
        end else begin
            m_stb  = rx_done && !m_prev;
            m_prev = rx_done;
            m_load = 1'b0;
            m_to   = 1'b0;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
            cyc++;
            if (frame_q.size() != 0) begin
                m_gap++;
                if (m_gap == TIMEOUT + 1) begin
                    m_to = 1'b1;
                    frame_q.delete();
                    push_ev(EV_TO, 8'h00, 8'h00, 8'h00);
                end
            end
`endif
            if (m_stb && !m_to) begin
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
                m_gap        = 0;
                last_stb_cyc = cyc;
`endif
                if (frame_q.size() != 0 || rx_data == SOF) frame_q.push_back(rx_data);
                if (frame_q.size() == 5) begin
                    if (frame_q[4] == (frame_q[1] ^ frame_q[2] ^ frame_q[3])) begin
                        if (!m_held || cmd_ready) begin
                            m_load = 1'b1;
                            push_ev(EV_CMD, frame_q[1], frame_q[2], frame_q[3]);
                        end else begin
                            push_ev(EV_OVR, 8'h00, 8'h00, 8'h00);
                        end
                    end else begin
                        push_ev(EV_CSUM, 8'h00, 8'h00, 8'h00);
                    end
                    frame_q.delete();
                end
            end
            if (m_load) m_held = 1'b1;
            else if (m_held && cmd_ready) m_held = 1'b0;
        end
    end

    // Monitor
    bit         mon_prev_valid = 1'b0;
    logic [7:0] mon_prev_op, mon_prev_addr, mon_prev_data;
    int         cmd_seen = 0, csum_seen = 0, ovr_seen = 0, to_seen = 0;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    int         to_delay = 0;
`endif

    task automatic pop_check(input ev_kind_e k, input logic [7:0] o, input logic [7:0] a,
                             input logic [7:0] d);
        ev_t e;
        check("sb_event_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_event_kind", k, e.kind);
            if (k == EV_CMD && e.kind == EV_CMD) begin
                check("sb_cmd_op", o, e.op);
                check("sb_cmd_addr", a, e.addr);
                check("sb_cmd_data", d, e.data);
            end
        end
    endtask

    always @(posedge clock) begin
        #1;
        check("cmd_valid_vs_model", cmd_valid, m_held);
        if (err_csum) begin
            csum_seen++;
            pop_check(EV_CSUM, 8'h00, 8'h00, 8'h00);
        end
        if (err_overrun) begin
            ovr_seen++;
            pop_check(EV_OVR, 8'h00, 8'h00, 8'h00);
        end
        if (err_timeout) begin
            to_seen++;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
            to_delay = cyc - last_stb_cyc;
`endif
            pop_check(EV_TO, 8'h00, 8'h00, 8'h00);
        end
        if (cmd_valid && (!mon_prev_valid || cmd_ready)) begin
            cmd_seen++;
            pop_check(EV_CMD, cmd_op, cmd_addr, cmd_data);
        end else if (cmd_valid && mon_prev_valid) begin
            check("held_op_stable", cmd_op, mon_prev_op);
            check("held_addr_stable", cmd_addr, mon_prev_addr);
            check("held_data_stable", cmd_data, mon_prev_data);
        end
        mon_prev_valid = cmd_valid;
        mon_prev_op    = cmd_op;
        mon_prev_addr  = cmd_addr;
        mon_prev_data  = cmd_data;
    end

    // Stimulus
    bit rand_ready = 1'b0;

    task automatic tick();
        @(negedge clock);
        if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        tick();
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [7:0] o, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] c, input int hold, input int gap);
        send_byte(SOF, hold, gap);
        send_byte(o, hold, gap);
        send_byte(a, hold, gap);
        send_byte(d, hold, gap);
        send_byte(c, hold, gap);
    endtask

    task automatic release_cmd();
        tick();
        cmd_ready = 1'b1;
        repeat (2) tick();
        cmd_ready = 1'b0;
        tick();
    endtask

    int         base;
    int         kind;
    int         hold;
    int         gap;
    logic [7:0] r_op, r_addr, r_data, r_csum, r_junk;

    initial begin
        reset     = 1'b1;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_op", cmd_op, 0);
        check("rst_cmd_addr", cmd_addr, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_err_csum", err_csum, 0);
        check("rst_err_overrun", err_overrun, 0);
        check("rst_err_timeout", err_timeout, 0);
        reset = 1'b0;
        tick();

        // Basic frame, latency of one cycle from checksum strobe, then handshake drop.
        send_byte(SOF, 1, 1);
        send_byte(8'h01, 1, 1);
        send_byte(8'h10, 1, 1);
        send_byte(8'hAA, 1, 1);
        @(negedge clock);
        rx_data = 8'hBB;
        rx_done = 1'b1;
        check("t1_valid_before_csum", cmd_valid, 0);
        @(posedge clock);
        #1;
        check("t1_latency_valid", cmd_valid, 1);
        check("t1_op", cmd_op, 8'h01);
        check("t1_addr", cmd_addr, 8'h10);
        check("t1_data", cmd_data, 8'hAA);
        @(negedge clock);
        rx_done   = 1'b0;
        cmd_ready = 1'b1;
        @(posedge clock);
        #1;
        check("t1_valid_drop", cmd_valid, 0);
        @(negedge clock);
        cmd_ready = 1'b0;

        // Bad checksum: good one would be 77.
        base = csum_seen;
        send_frame(8'h02, 8'h20, 8'h55, 8'h00, 1, 1);
        repeat (2) tick();
        check("t2_csum_pulses", csum_seen - base, 1);
        check("t2_no_cmd", cmd_valid, 0);

        // Leading garbage ignored; SOF value inside the frame is plain data.
        base = cmd_seen;
        send_byte(8'h00, 1, 1);
        send_byte(8'hFF, 1, 1);
        send_frame(8'h03, 8'h30, 8'h7E, 8'h4D, 1, 1);
        repeat (2) tick();
        check("t3_one_cmd", cmd_seen - base, 1);
        check("t3_op", cmd_op, 8'h03);
        check("t3_addr", cmd_addr, 8'h30);
        check("t3_data", cmd_data, 8'h7E);
        release_cmd();

        // Back-to-back with consumer stalled: second frame overruns, first retained.
        base = ovr_seen;
        send_frame(8'h11, 8'h22, 8'h33, 8'h00, 1, 1);
        send_frame(8'h44, 8'h55, 8'h66, 8'h77, 1, 1);
        repeat (2) tick();
        check("t4_overrun_pulses", ovr_seen - base, 1);
        check("t4_kept_op", cmd_op, 8'h11);
        check("t4_kept_addr", cmd_addr, 8'h22);
        check("t4_kept_data", cmd_data, 8'h33);
        // Same again, but ready coincides with the checksum strobe: replace, no overrun.
        send_byte(SOF, 1, 1);
        send_byte(8'h0A, 1, 1);
        send_byte(8'h0B, 1, 1);
        send_byte(8'h0C, 1, 1);
        tick();
        rx_data   = 8'h0D;
        rx_done   = 1'b1;
        cmd_ready = 1'b1;
        tick();
        rx_done   = 1'b0;
        cmd_ready = 1'b0;
        repeat (2) tick();
        check("t4_no_new_overrun", ovr_seen - base, 1);
        check("t4_replace_valid", cmd_valid, 1);
        check("t4_replace_op", cmd_op, 8'h0A);
        check("t4_replace_addr", cmd_addr, 8'h0B);
        check("t4_replace_data", cmd_data, 8'h0C);
        release_cmd();

        // uart_rx-style long done level; reset mid-frame, done held high across release.
        base = cmd_seen;
        send_byte(SOF, HOLD_L, 2);
        send_byte(8'h01, HOLD_L, 2);
        tick();
        reset   = 1'b1;
        rx_data = SOF;
        rx_done = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        rx_done = 1'b0;
        tick();
        check("t5_idle_after_reset", cmd_valid, 0);
        send_frame(8'h01, 8'h10, 8'hAA, 8'hBB, HOLD_L, 2);
        repeat (2) tick();
        check("t5_one_cmd", cmd_seen - base, 1);
        check("t5_op", cmd_op, 8'h01);
        check("t5_addr", cmd_addr, 8'h10);
        check("t5_data", cmd_data, 8'hAA);
        release_cmd();

        // Long silence inside a frame.
        base = cmd_seen;
        kind = to_seen;
        send_byte(SOF, 1, 1);
        send_byte(8'h01, 1, 1);
        repeat (9000) tick();
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        check("t6_timeout_pulses", to_seen - kind, 1);
        check("t6_timeout_delay_ok", (to_delay >= TIMEOUT) && (to_delay <= TIMEOUT + 2), 1);
`else
        check("t6_no_timeout", to_seen - kind, 0);
`endif
        send_byte(8'h10, 1, 1);
        send_byte(8'hAA, 1, 1);
        send_byte(8'hBB, 1, 1);
        repeat (2) tick();
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        check("t6_tail_ignored", cmd_seen - base, 0);
        send_frame(8'h01, 8'h10, 8'hAA, 8'hBB, 1, 1);
        repeat (2) tick();
`endif
        check("t6_one_cmd", cmd_seen - base, 1);
        check("t6_op", cmd_op, 8'h01);
        check("t6_addr", cmd_addr, 8'h10);
        check("t6_data", cmd_data, 8'hAA);
        release_cmd();

        // Randomised mix of good frames, corrupted checksums and inter-frame noise.
        rand_ready = 1'b1;
        for (int f = 0; f < 80; f++) begin
            kind   = int'($urandom_range(0, 9));
            hold   = int'($urandom_range(1, 4));
            gap    = int'($urandom_range(1, 3));
            r_op   = 8'($urandom);
            r_addr = 8'($urandom);
            r_data = 8'($urandom);
            if (kind < 2) begin
                r_junk = 8'($urandom);
                if (r_junk == SOF) r_junk = 8'h00;
                send_byte(r_junk, hold, gap);
            end else begin
                r_csum = r_op ^ r_addr ^ r_data;
                if (kind < 4) r_csum = r_csum ^ 8'($urandom_range(1, 255));
                send_frame(r_op, r_addr, r_data, r_csum, hold, gap);
            end
        end
        rand_ready = 1'b0;
        release_cmd();
        repeat (2) tick();
        check("sb_drained", exp_q.size(), 0);
        check("final_valid_low", cmd_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at t=%0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
